// File: rtl/mpadd_pkg.sv
// Shared constants and FSM state type for the mpadd32 multi-precision adder.
package mpadd_pkg;

  localparam int WORD_W  = 32;
  localparam int N_WORDS = 8;
  localparam int OP_W    = WORD_W * N_WORDS;
  localparam int CNT_W   = $clog2(N_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mpadd32_adder32.sv
// Combinational limb adder: WORD_W-bit sum with carry-in and carry-out.
module adder32
  import mpadd_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mpadd32.sv
// 256-bit adder iterating one 32-bit limb per cycle with a carry register.
// Optional MPADD32_BUSY_EN adds a busy output that is high while in RUN.
module mpadd32
  import mpadd_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic [OP_W-1:0] a_in,
  input  logic [OP_W-1:0] b_in,
  input  logic            write,
  input  logic            start,
  output logic [OP_W:0]   s_out,
  output logic            ready
`ifdef MPADD32_BUSY_EN
  ,
  output logic            busy
`endif
);

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               carry_r;
  logic [OP_W-1:0]    a_r;
  logic [OP_W-1:0]    b_r;
  logic [WORD_W-1:0]  a_limb_s;
  logic [WORD_W-1:0]  b_limb_s;
  logic [WORD_W-1:0]  sum_limb_s;
  logic               cout_s;
`ifdef MPADD32_BUSY_EN
  logic               busy_r;
`endif

  assign a_limb_s = a_r[cnt_r * WORD_W +: WORD_W];
  assign b_limb_s = b_r[cnt_r * WORD_W +: WORD_W];

  adder32 #(.W(WORD_W)) u_adder (
    .a    (a_limb_s),
    .b    (b_limb_s),
    .cin  (carry_r),
    .sum  (sum_limb_s),
    .cout (cout_s)
  );

  // Control FSM, operand capture and limb-wise result accumulation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      s_out   <= '0;
      ready   <= 1'b0;
`ifdef MPADD32_BUSY_EN
      busy_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (write) begin
            a_r <= a_in;
            b_r <= b_in;
          end else if (start) begin
            cnt_r   <= '0;
            carry_r <= 1'b0;
            state_r <= RUN;
`ifdef MPADD32_BUSY_EN
            busy_r  <= 1'b1;
`endif
          end
        end
        RUN: begin
          // write/start are deliberately ignored here so operands stay stable
          s_out[cnt_r * WORD_W +: WORD_W] <= sum_limb_s;
          carry_r <= cout_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(N_WORDS - 1)) begin
            s_out[OP_W] <= cout_s;
            ready       <= 1'b1;
            state_r     <= DONE;
`ifdef MPADD32_BUSY_EN
            busy_r      <= 1'b0;
`endif
          end
        end
        DONE: begin
          if (write) begin
            a_r     <= a_in;
            b_r     <= b_in;
            ready   <= 1'b0;
            state_r <= IDLE;
          end else if (start) begin
            cnt_r   <= '0;
            carry_r <= 1'b0;
            ready   <= 1'b0;
            state_r <= RUN;
`ifdef MPADD32_BUSY_EN
            busy_r  <= 1'b1;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          ready   <= 1'b0;
`ifdef MPADD32_BUSY_EN
          busy_r  <= 1'b0;
`endif
        end
      endcase
    end
  end

`ifdef MPADD32_BUSY_EN
  assign busy = busy_r;
`endif

endmodule

// File: tb/tb_mpadd32.sv
// Self-checking bench for mpadd32: directed handshake cases plus LFSR-driven regression.
module tb_mpadd32;

  logic         CLK = 1'b0;
  logic         RST;
  logic [255:0] a_in;
  logic [255:0] b_in;
  logic         write;
  logic         start;
  logic [256:0] s_out;
  logic         ready;
`ifdef MPADD32_BUSY_EN
  logic         busy;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mpadd32 dut (
    .CLK   (CLK),
    .RST   (RST),
    .a_in  (a_in),
    .b_in  (b_in),
    .write (write),
    .start (start),
    .s_out (s_out),
    .ready (ready)
`ifdef MPADD32_BUSY_EN
    ,
    .busy  (busy)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [256:0] ref_sum(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] wa;
    logic [256:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return wa + wb;
  endfunction

  function automatic logic [255:0] lfsr_next(input logic [255:0] x);
    logic [255:0] m;
    m = '0;
    m[255] = 1'b1;
    m[9]   = 1'b1;
    m[4]   = 1'b1;
    m[1]   = 1'b1;
    return x[0] ? ((x >> 1) ^ m) : (x >> 1);
  endfunction

  task automatic do_write(input logic [255:0] a, input logic [255:0] b);
    a_in  = a;
    b_in  = b;
    write = 1'b1;
    tick();
    write = 1'b0;
    chk1("ready_after_write", ready, 1'b0);
  endtask

  // Pulse start, require ready low on edges N..N+7, then the result at N+8.
  task automatic start_and_wait(input string tag, input logic [256:0] exp, input bit disturb);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1({tag, "_ready_N"}, ready, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      if (disturb && i == 3) begin
        a_in  = ~a_in;
        b_in  = ~b_in;
        write = 1'b1;
        start = 1'b1;
      end
`ifdef MPADD32_BUSY_EN
      chk1({tag, "_busy"}, busy, 1'b1);
`endif
      tick();
      write = 1'b0;
      start = 1'b0;
      if (i < 8) begin
        chk1({tag, "_ready_low"}, ready, 1'b0);
      end else begin
        chk1({tag, "_ready_high"}, ready, 1'b1);
        chk({tag, "_sum"}, s_out, exp);
      end
    end
  endtask

  initial begin
    logic [255:0] ones;
    logic [255:0] la;
    logic [255:0] lb;
    logic [255:0] xa;
    logic [255:0] xb;
    logic [256:0] prev;
    int gap;

    RST   = 1'b1;
    write = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    tick();
    tick();
    RST = 1'b0;
    chk1("reset_ready", ready, 1'b0);
    chk("reset_sum", s_out, 257'd0);
`ifdef MPADD32_BUSY_EN
    chk1("reset_busy", busy, 1'b0);
`endif

    // Start with no prior write adds the cleared operand registers.
    start_and_wait("nowrite", 257'd0, 1'b0);

    do_write(256'd0, 256'd0);
    start_and_wait("zero", 257'd0, 1'b0);

    ones = {256{1'b1}};
    do_write(ones, 256'd1);
    start_and_wait("allones", ref_sum(ones, 256'd1), 1'b0);
    chk("allones_carry", {256'd0, s_out[256]}, 257'd1);
    start_and_wait("recompute", ref_sum(ones, 256'd1), 1'b0);

    do_write(256'h0000_0000_FFFF_FFFF, 256'd1);
    start_and_wait("limbcarry", 257'h1_0000_0000, 1'b1);

    // write+start together: only the load happens.
    xa = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    a_in  = xa;
    b_in  = xb;
    write = 1'b1;
    start = 1'b1;
    tick();
    write = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk1("wr_start_no_compute", ready, 1'b0);
      tick();
    end
    start_and_wait("wr_start_load", ref_sum(xa, xb), 1'b0);

    // Reset in the middle of an operation.
    do_write(256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1234,
             256'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midreset_sum", s_out, 257'd0);
    chk1("midreset_ready", ready, 1'b0);
    start_and_wait("after_reset_zero_ops", 257'd0, 1'b0);
    do_write(256'd123456789, ones);
    start_and_wait("after_reset", ref_sum(256'd123456789, ones), 1'b0);

    // LFSR regression with random idle gaps while results are held.
    la   = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
    lb   = 256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5;
    prev = ref_sum(256'd123456789, ones);
    for (int n = 0; n < 1000; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk1("hold_ready", ready, 1'b1);
        chk("hold_sum", s_out, prev);
      end
      do_write(la, lb);
      prev = ref_sum(la, lb);
      start_and_wait("rand", prev, 1'b0);
      la = lfsr_next(la);
      lb = lfsr_next(lb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpadd32.md
Name: mpadd32

Overview:
- Multi-precision 256-bit adder built around one 32-bit limb adder, iterated over 8 limbs with a carry register.
- Produces a 257-bit sum, including the carry-out, in 8 cycles after start.
- Operands are captured by a write strobe; completion is flagged by a level `ready`.
- Area-lean datapath block for the arithmetic unit, replacing a full-width 256-bit adder.

Parameters:
- WORD_W, 32, limb width in bits.
- N_WORDS, 8, number of limbs; operand width = WORD_W*N_WORDS = 256.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- a_in  input  256  operand A; sampled only when write=1.
- b_in  input  256  operand B; sampled only when write=1.
- write  input  1  single-cycle strobe that loads a_in/b_in into internal operand registers.
- start  input  1  single-cycle strobe that begins an addition on the stored operands.
- s_out  output  257  sum {carry, 256-bit sum}; registered; valid while ready=1.
- ready  output  1  high when s_out holds the result of the latest start.

Behaviour:
- Reset (RST=1 at a clock edge): clears s_out, ready, operand registers, limb counter and carry; state=IDLE. Reset mid-operation aborts it immediately with no partial result.
- States and transitions:
  - IDLE, ready=0:
    - write=1: load A_reg/B_reg; ready stays 0.
    - start=1 (write=0): counter=0, carry=0, go to RUN.
  - RUN: one limb per edge. Limb i: {c, s_out[32i+31:32i]} = A_reg limb i + B_reg limb i + carry. Carry register takes c. Counter increments.
    - After limb 7: s_out[256] = final carry, ready=1, go to DONE.
  - DONE, ready=1, s_out held stable:
    - write=1: load operands, ready=0, go to IDLE.
    - start=1: recompute on the stored operands; ready=0, go to RUN.
- Latency: start sampled at edge N gives ready=1 and a valid s_out at edge N+8. ready=0 on edges N through N+7.
- ready must be 0 on the edge after any write or start, so stale results are never flagged.
- write and start high in the same cycle: write wins, start is ignored.
- write or start while in RUN: ignored; operands stay protected.
- start without any prior write adds the current registers, which are 0 after reset.
- Arithmetic is unsigned modulo 2^257, so carry-out is never lost. Example: all-ones + 1 gives s_out = 1 followed by 256 zeros.
- Upper s_out limbs may show partial values during RUN; only ready=1 qualifies s_out.

Optional Feature:
- Macro MPADD32_BUSY_EN.
- Defined: adds output port busy (1 bit), equal to 1 exactly while in RUN; reset value 0.
- Undefined: no busy port.
- All other behaviour and timing are identical in both builds.

Decomposition:
- Package mpadd_pkg: WORD_W, N_WORDS, CNT_W = $clog2(N_WORDS), and a state enum {IDLE, RUN, DONE}.
- One sub-module: adder32, a combinational WORD_W-bit adder with carry-in and carry-out.
- Limb selection muxes, counter and FSM stay in mpadd32.

Test Plan:
- Reset, then write a=0, b=0, start → ready at N+8, s_out=0.
- a=2^256-1, b=1 → s_out[256]=1, s_out[255:0]=0.
- Carry chain across limbs: a=0x...0000_0000_FFFF_FFFF, b=1 → s_out=0x1_0000_0000.
- Timing/handshake:
  - ready stays 0 for edges N..N+7 and is 1 at N+8.
  - A following write drops ready on the next edge.
  - write+start together → only the load occurs, no computation.
- Assert RST at cycle N+4 of an operation → next edge s_out=0, ready=0. Then a new write/start completes correctly.
- Random regression: 1000 back-to-back write/start/wait-ready cycles with 256-bit LFSR operands.
  - Seed A=6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296.
  - Seed B=4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5.
  - Check s_out == {0,a}+{0,b} each time; 0 errors required.
